// File: rtl/decode_pkg.sv
// ============================================================================
// decode_pkg: shared encodings, one-hot bit indices and entry type for the
// buffered MIPS-32 instruction decoder.  Rev 1.0
// ============================================================================
`default_nettype none

package decode_pkg;

    localparam int CODE_W = 54;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE    = 6'b000000;
    localparam logic [5:0] OP_REGIMM   = 6'b000001;
    localparam logic [5:0] OP_J        = 6'b000010;
    localparam logic [5:0] OP_JAL      = 6'b000011;
    localparam logic [5:0] OP_BEQ      = 6'b000100;
    localparam logic [5:0] OP_BNE      = 6'b000101;
    localparam logic [5:0] OP_ADDI     = 6'b001000;
    localparam logic [5:0] OP_ADDIU    = 6'b001001;
    localparam logic [5:0] OP_SLTI     = 6'b001010;
    localparam logic [5:0] OP_SLTIU    = 6'b001011;
    localparam logic [5:0] OP_ANDI     = 6'b001100;
    localparam logic [5:0] OP_ORI      = 6'b001101;
    localparam logic [5:0] OP_XORI     = 6'b001110;
    localparam logic [5:0] OP_LUI      = 6'b001111;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
    localparam logic [5:0] OP_LB       = 6'b100000;
    localparam logic [5:0] OP_LH       = 6'b100001;
    localparam logic [5:0] OP_LW       = 6'b100011;
    localparam logic [5:0] OP_LBU      = 6'b100100;
    localparam logic [5:0] OP_LHU      = 6'b100101;
    localparam logic [5:0] OP_SB       = 6'b101000;
    localparam logic [5:0] OP_SH       = 6'b101001;
    localparam logic [5:0] OP_SW       = 6'b101011;

    // R-type funct (instr[5:0] with opcode 000000)
    localparam logic [5:0] FN_SLL     = 6'b000000;
    localparam logic [5:0] FN_SRL     = 6'b000010;
    localparam logic [5:0] FN_SRA     = 6'b000011;
    localparam logic [5:0] FN_SLLV    = 6'b000100;
    localparam logic [5:0] FN_SRLV    = 6'b000110;
    localparam logic [5:0] FN_SRAV    = 6'b000111;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;
    localparam logic [5:0] FN_SYSCALL = 6'b001100;
    localparam logic [5:0] FN_BREAK   = 6'b001101;
    localparam logic [5:0] FN_MFHI    = 6'b010000;
    localparam logic [5:0] FN_MTHI    = 6'b010001;
    localparam logic [5:0] FN_MFLO    = 6'b010010;
    localparam logic [5:0] FN_MTLO    = 6'b010011;
    localparam logic [5:0] FN_MULTU   = 6'b011001;
    localparam logic [5:0] FN_DIV     = 6'b011010;
    localparam logic [5:0] FN_DIVU    = 6'b011011;
    localparam logic [5:0] FN_ADD     = 6'b100000;
    localparam logic [5:0] FN_ADDU    = 6'b100001;
    localparam logic [5:0] FN_SUB     = 6'b100010;
    localparam logic [5:0] FN_SUBU    = 6'b100011;
    localparam logic [5:0] FN_AND     = 6'b100100;
    localparam logic [5:0] FN_OR      = 6'b100101;
    localparam logic [5:0] FN_XOR     = 6'b100110;
    localparam logic [5:0] FN_NOR     = 6'b100111;
    localparam logic [5:0] FN_SLT     = 6'b101010;
    localparam logic [5:0] FN_SLTU    = 6'b101011;
    localparam logic [5:0] FN_TEQ     = 6'b110100;

    // SPECIAL2 funct (opcode 011100)
    localparam logic [5:0] FN2_MUL = 6'b000010;
    localparam logic [5:0] FN2_CLZ = 6'b100000;

    // Coprocessor-0 forms
    localparam logic [10:0] COP0_MFC0 = 11'b01000_000000;
    localparam logic [10:0] COP0_MTC0 = 11'b01000_000100;
    localparam logic [31:0] ERET_WORD = 32'h4200_0018;

    // One-hot bit positions
    localparam int B_ADD = 0,    B_ADDU = 1,  B_SUB = 2,   B_SUBU = 3,   B_AND = 4;
    localparam int B_OR = 5,     B_XOR = 6,   B_NOR = 7,   B_SLT = 8,    B_SLTU = 9;
    localparam int B_SLL = 10,   B_SRL = 11,  B_SRA = 12,  B_SLLV = 13,  B_SRLV = 14;
    localparam int B_SRAV = 15,  B_JR = 16,   B_ADDI = 17, B_ADDIU = 18, B_ANDI = 19;
    localparam int B_ORI = 20,   B_XORI = 21, B_LUI = 22,  B_LW = 23,    B_SW = 24;
    localparam int B_BEQ = 25,   B_BNE = 26,  B_SLTI = 27, B_SLTIU = 28, B_J = 29;
    localparam int B_JAL = 30,   B_CLZ = 31,  B_MUL = 32,  B_JALR = 33,  B_DIVU = 34;
    localparam int B_DIV = 35,   B_MULTU = 36, B_LB = 37,  B_LBU = 38,   B_LH = 39;
    localparam int B_LHU = 40,   B_SB = 41,   B_SH = 42,   B_BGEZ = 43,  B_MFHI = 44;
    localparam int B_MTHI = 45,  B_MFLO = 46, B_MTLO = 47, B_ERET = 48,  B_SYSCALL = 49;
    localparam int B_TEQ = 50,   B_BREAK = 51, B_MFC0 = 52, B_MTC0 = 53;

    // Decoded part of a FIFO entry; the PC field is appended by the queue
    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              illegal;
        logic [31:0]       instr;
    } dec_word_t;

endpackage

`default_nettype wire

// File: rtl/instr_onehot_decode.sv
// ============================================================================
// instr_onehot_decode: combinational MIPS-32 word to 54-bit one-hot decoder
// with an explicit illegal flag.  Rev 1.0
// ============================================================================
`default_nettype none

module instr_onehot_decode
    import decode_pkg::*;
(
    input  logic [31:0]       instr,
    output logic [CODE_W-1:0] code,
    output logic              illegal
);

    logic [5:0] w_op;
    logic [5:0] w_fn;

    assign w_op = instr[31:26];
    assign w_fn = instr[5:0];

    always_comb begin
        code = '0;
        case (w_op)
            OP_RTYPE: begin
                case (w_fn)
                    FN_ADD:     code[B_ADD]     = 1'b1;
                    FN_ADDU:    code[B_ADDU]    = 1'b1;
                    FN_SUB:     code[B_SUB]     = 1'b1;
                    FN_SUBU:    code[B_SUBU]    = 1'b1;
                    FN_AND:     code[B_AND]     = 1'b1;
                    FN_OR:      code[B_OR]      = 1'b1;
                    FN_XOR:     code[B_XOR]     = 1'b1;
                    FN_NOR:     code[B_NOR]     = 1'b1;
                    FN_SLT:     code[B_SLT]     = 1'b1;
                    FN_SLTU:    code[B_SLTU]    = 1'b1;
                    FN_SLL:     code[B_SLL]     = 1'b1;
                    FN_SRL:     code[B_SRL]     = 1'b1;
                    FN_SRA:     code[B_SRA]     = 1'b1;
                    FN_SLLV:    code[B_SLLV]    = 1'b1;
                    FN_SRLV:    code[B_SRLV]    = 1'b1;
                    FN_SRAV:    code[B_SRAV]    = 1'b1;
                    FN_JR:      code[B_JR]      = 1'b1;
                    FN_JALR:    code[B_JALR]    = 1'b1;
                    FN_DIVU:    code[B_DIVU]    = 1'b1;
                    FN_DIV:     code[B_DIV]     = 1'b1;
                    FN_MULTU:   code[B_MULTU]   = 1'b1;
                    FN_MFHI:    code[B_MFHI]    = 1'b1;
                    FN_MTHI:    code[B_MTHI]    = 1'b1;
                    FN_MFLO:    code[B_MFLO]    = 1'b1;
                    FN_MTLO:    code[B_MTLO]    = 1'b1;
                    FN_SYSCALL: code[B_SYSCALL] = 1'b1;
                    FN_TEQ:     code[B_TEQ]     = 1'b1;
                    FN_BREAK:   code[B_BREAK]   = 1'b1;
                    default:    ;
                endcase
            end
            OP_SPECIAL2: begin
                case (w_fn)
                    FN2_CLZ: code[B_CLZ] = 1'b1;
                    FN2_MUL: code[B_MUL] = 1'b1;
                    default: ;
                endcase
            end
            OP_ADDI:   code[B_ADDI]  = 1'b1;
            OP_ADDIU:  code[B_ADDIU] = 1'b1;
            OP_ANDI:   code[B_ANDI]  = 1'b1;
            OP_ORI:    code[B_ORI]   = 1'b1;
            OP_XORI:   code[B_XORI]  = 1'b1;
            OP_LUI:    code[B_LUI]   = 1'b1;
            OP_LW:     code[B_LW]    = 1'b1;
            OP_SW:     code[B_SW]    = 1'b1;
            OP_BEQ:    code[B_BEQ]   = 1'b1;
            OP_BNE:    code[B_BNE]   = 1'b1;
            OP_SLTI:   code[B_SLTI]  = 1'b1;
            OP_SLTIU:  code[B_SLTIU] = 1'b1;
            OP_J:      code[B_J]     = 1'b1;
            OP_JAL:    code[B_JAL]   = 1'b1;
            OP_LB:     code[B_LB]    = 1'b1;
            OP_LBU:    code[B_LBU]   = 1'b1;
            OP_LH:     code[B_LH]    = 1'b1;
            OP_LHU:    code[B_LHU]   = 1'b1;
            OP_SB:     code[B_SB]    = 1'b1;
            OP_SH:     code[B_SH]    = 1'b1;
            OP_REGIMM: code[B_BGEZ]  = 1'b1;
            default:   ;
        endcase
        // COP0 forms share opcode 010000 but are disjoint from each other
        code[B_ERET] = (instr == ERET_WORD);
        code[B_MFC0] = (instr[31:21] == COP0_MFC0);
        code[B_MTC0] = (instr[31:21] == COP0_MTC0);
    end

    assign illegal = ~|code;

endmodule

`default_nettype wire

// File: rtl/decode_queue.sv
// ============================================================================
// decode_queue: decodes fetched words on the push side and buffers them in a
// DEPTH-entry FIFO feeding the control unit.  Rev 1.0
// ============================================================================
`default_nettype none

module decode_queue
    import decode_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [PC_W-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CODE_W-1:0]        out_code,
    output logic                     out_illegal,
    output logic [31:0]              out_instr,
    output logic [PC_W-1:0]          out_pc,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         illegal_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        dec_word_t       dec;
        logic [PC_W-1:0] pc;
    } entry_t;

    entry_t            r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic [CNT_W-1:0]  r_ill_cnt;

    logic [CODE_W-1:0] w_code;
    logic              w_illegal;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    entry_t            w_wr_entry;
    entry_t            w_head;

    instr_onehot_decode u_decode (
        .instr   (in_instr),
        .code    (w_code),
        .illegal (w_illegal)
    );

    assign w_full   = (r_level == LW'(DEPTH));
    assign w_empty  = (r_level == '0);
    assign in_ready = !w_full && rst_n;
    assign out_valid = !w_empty;
    assign w_push   = in_valid && in_ready && !flush;
    assign w_pop    = out_valid && out_ready && !flush;

    assign w_wr_entry.dec.code    = w_code;
    assign w_wr_entry.dec.illegal = w_illegal;
    assign w_wr_entry.dec.instr   = in_instr;
    assign w_wr_entry.pc          = in_pc;

    // Pointers are AW bits wide, so DEPTH being a power of two gives the wrap for free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_level <= r_level + 1'b1;
            else if (!w_push && w_pop) r_level <= r_level - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ill_cnt <= '0;
        end else if (w_push && w_illegal && (r_ill_cnt != '1)) begin
            r_ill_cnt <= r_ill_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_wr_entry;
    end

    // Head fields are forced to zero whenever nothing valid is held
    assign w_head        = r_mem[r_rd_ptr];
    assign out_code      = out_valid ? w_head.dec.code  : '0;
    assign out_illegal   = out_valid & w_head.dec.illegal;
    assign out_instr     = out_valid ? w_head.dec.instr : '0;
    assign out_pc        = out_valid ? w_head.pc        : '0;
    assign level         = r_level;
    assign illegal_count = r_ill_cnt;

endmodule

`default_nettype wire

// File: tb/tb_decode_queue.sv
// ============================================================================
// tb_decode_queue: directed and randomized checks of decode_queue against a
// table-driven reference decoder and a queue model.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_decode_queue;

    localparam int DEPTH   = 2;
    localparam int PC_W    = 32;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // Reference encoding table indexed by one-hot bit: opcode, funct (-1 = any / special)
    localparam int TBL_OP [54] = '{
        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
        8, 9, 12, 13, 14, 15, 35, 43, 4, 5, 10, 11, 2, 3,
        28, 28, 0, 0, 0, 0, 32, 36, 33, 37, 40, 41, 1,
        0, 0, 0, 0, -1, 0, 0, 0, -1, -1};
    localparam int TBL_FN [54] = '{
        32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 0, 2, 3, 4, 6, 7, 8,
        -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1,
        32, 2, 9, 27, 26, 25, -1, -1, -1, -1, -1, -1, -1,
        16, 17, 18, 19, -1, 12, 52, 13, -1, -1};

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    logic                 clk;
    logic                 rst_n;
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_instr;
    logic [PC_W-1:0]      in_pc;
    logic                 out_valid;
    logic                 out_ready;
    logic [53:0]          out_code;
    logic                 out_illegal;
    logic [31:0]          out_instr;
    logic [PC_W-1:0]      out_pc;
    logic [$clog2(DEPTH):0] level;
    logic [CNT_W-1:0]     illegal_count;

    ent_t mq[$];
    int   mcnt;
    int   n_total;
    int   n_pass;
    int   n_fail;

    decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_code      (out_code),
        .out_illegal   (out_illegal),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .level         (level),
        .illegal_count (illegal_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [53:0] ref_code(input logic [31:0] w);
        logic [53:0] c;
        int op;
        int fn;
        c  = '0;
        op = int'(w[31:26]);
        fn = int'(w[5:0]);
        for (int i = 0; i < 54; i++) begin
            if (TBL_OP[i] >= 0 && op == TBL_OP[i] && (TBL_FN[i] < 0 || fn == TBL_FN[i]))
                c[i] = 1'b1;
        end
        c[48] = (w == 32'h4200_0018);
        c[52] = (w[31:21] == 11'h200);
        c[53] = (w[31:21] == 11'h204);
        return c;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        int k;
        int i;
        int t;
        w = $urandom;
        k = $urandom_range(0, 99);
        if (k < 60) begin
            i = $urandom_range(0, 53);
            if (i == 48) w = 32'h4200_0018;
            else if (i == 52) w[31:21] = 11'h200;
            else if (i == 53) w[31:21] = 11'h204;
            else begin
                t = TBL_OP[i];
                w[31:26] = 6'(t);
                t = TBL_FN[i];
                if (t >= 0) w[5:0] = 6'(t);
            end
        end
        return w;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [53:0] ec;
        ent_t        h;
        ec = '0;
        h  = '0;
        if (mq.size() > 0) begin
            h  = mq[0];
            ec = ref_code(h.instr);
        end
        check("out_valid",     64'(out_valid),     64'(mq.size() > 0));
        check("level",         64'(level),         64'(mq.size()));
        check("in_ready",      64'(in_ready),      64'(rst_n && (mq.size() < DEPTH)));
        check("out_code",      64'(out_code),      64'(ec));
        check("out_illegal",   64'(out_illegal),   64'((mq.size() > 0) && (ec == '0)));
        check("out_instr",     64'(out_instr),     64'(h.instr));
        check("out_pc",        64'(out_pc),        64'(h.pc));
        check("illegal_count", 64'(illegal_count), 64'(mcnt));
    endtask

    task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        in_valid  = v;
        in_instr  = w;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
    endtask

    // One clock: model the edge from the inputs presented before it, then compare
    task automatic step();
        bit   push;
        bit   pop;
        ent_t e;
        push = rst_n && in_valid && (mq.size() < DEPTH) && !flush;
        pop  = rst_n && (mq.size() > 0) && out_ready && !flush;
        e.instr = in_instr;
        e.pc    = in_pc;
        @(posedge clk);
        if (rst_n) begin
            if (flush) begin
                mq.delete();
            end else begin
                if (pop) void'(mq.pop_front());
                if (push) begin
                    mq.push_back(e);
                    if (ref_code(e.instr) == '0 && mcnt < CNT_MAX) mcnt++;
                end
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        n_fail  = 0;
        mcnt    = 0;
        rst_n   = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #12;
        check_all();
        rst_n = 1'b1;

        // Single add flows through with one cycle latency
        drive(1'b1, 32'h0022_1820, 32'h0000_1000, 1'b1, 1'b0);
        step();
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_code",  64'(out_code),  64'h1);
        check("t1_pc",    64'(out_pc),    64'h1000);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();

        // eret, mtc0, illegal
        drive(1'b1, 32'h4200_0018, 32'h0000_2000, 1'b1, 1'b0);
        step();
        check("t2_eret", 64'(out_code), 64'(54'h1) << 48);
        drive(1'b1, 32'h4080_6000, 32'h0000_2004, 1'b1, 1'b0);
        step();
        check("t2_mtc0", 64'(out_code), 64'(54'h1) << 53);
        drive(1'b1, 32'hFC00_0000, 32'h0000_2008, 1'b1, 1'b0);
        step();
        check("t2_ill_code", 64'(out_code), 64'd0);
        check("t2_ill_flag", 64'(out_illegal), 64'd1);
        check("t2_ill_cnt",  64'(illegal_count), 64'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();

        // Back-pressure: fill, hold the third word, then drain in order
        drive(1'b1, 32'h2001_0001, 32'h0000_3000, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h2001_0002, 32'h0000_3004, 1'b0, 1'b0);
        step();
        check("t3_full_rdy", 64'(in_ready), 64'd0);
        check("t3_full_lvl", 64'(level), 64'd2);
        drive(1'b1, 32'h2001_0003, 32'h0000_3008, 1'b0, 1'b0);
        step();
        check("t3_hold_lvl", 64'(level), 64'd2);
        check("t3_head_a",   64'(out_instr), 64'h2001_0001);
        drive(1'b1, 32'h2001_0003, 32'h0000_3008, 1'b1, 1'b0);
        step();
        check("t3_head_b", 64'(out_instr), 64'h2001_0002);
        step();
        check("t3_head_c", 64'(out_instr), 64'h2001_0003);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        check("t3_empty", 64'(out_valid), 64'd0);

        // Flush a full queue while an illegal word is offered
        drive(1'b1, 32'h3402_00FF, 32'h0000_4000, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h8C43_0004, 32'h0000_4004, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'hFC00_0000, 32'h0000_4008, 1'b0, 1'b1);
        step();
        check("t4_lvl",   64'(level), 64'd0);
        check("t4_valid", 64'(out_valid), 64'd0);
        check("t4_cnt",   64'(illegal_count), 64'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();

        // Saturating illegal counter
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'hFFFF_0000 | 32'(i), 32'h0000_5000 + 32'(4 * i), 1'b1, 1'b0);
            step();
        end
        check("t5_sat", 64'(illegal_count), 64'(CNT_MAX));
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();

        // Asynchronous reset with two entries held
        drive(1'b1, 32'h0C00_0010, 32'h0000_6000, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h0000_000C, 32'h0000_6004, 1'b0, 1'b0);
        step();
        check("t6_pre_lvl", 64'(level), 64'd2);
        #2;
        rst_n = 1'b0;
        mq.delete();
        mcnt = 0;
        #1;
        check_all();
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_lvl",   64'(level), 64'd0);
        check("t6_rst_rdy",   64'(in_ready), 64'd0);
        check("t6_rst_cnt",   64'(illegal_count), 64'd0);
        step();
        #2;
        rst_n = 1'b1;
        #1;
        check("t6_rel_rdy", 64'(in_ready), 64'd1);
        drive(1'b1, 32'h0022_1820, 32'h0000_7000, 1'b1, 1'b0);
        step();
        check("t6_fresh_code", 64'(out_code), 64'h1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 9) < 7, gen_instr(), $urandom,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
